// File: rtl/bsort_stream_pkg.sv
// Shared definitions for the streaming bubble sorter: FSM state encodings
// and a clog2 helper that never returns less than one bit.
package bsort_stream_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Counter width for n states; a 1-element counter still needs one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bsort_chain.sv
// One full bubble pass over a packed array: a combinational compare-swap
// chain that carries the running maximum from index 0 to index DIM-1.
module bsort_chain #(
    parameter int DIM   = 8,
    parameter int WIDTH = 8
) (
    input  logic [DIM*WIDTH-1:0] i_arr,
    output logic [DIM*WIDTH-1:0] o_arr
);

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_next;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_arr   = '0;
        w_next  = '0;
        w_carry = i_arr[WIDTH-1:0];
        // NOTE: blocking assignments here so w_carry updates ripple through
        // the loop within the same evaluation.
        for (int i = 0; i < DIM - 1; i++) begin
            w_next = i_arr[(i+1)*WIDTH +: WIDTH];
            // Strict compare keeps equal elements in place: the sort is stable.
            if (w_carry > w_next) begin
                o_arr[i*WIDTH +: WIDTH] = w_next;
            end else begin
                o_arr[i*WIDTH +: WIDTH] = w_carry;
                w_carry                 = w_next;
            end
        end
        o_arr[(DIM-1)*WIDTH +: WIDTH] = w_carry;
    end

endmodule

// File: rtl/bsort_stream.sv
// Serial loader / sorter / drainer: collects DIM elements over a valid/ready
// stream, runs DIM-1 bubble passes, then streams the sorted array out.
module bsort_stream
    import bsort_stream_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_dat,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [WIDTH-1:0]     out_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_last,
    output logic [DIM*WIDTH-1:0] out_arr,
    output logic                 busy
);

    localparam int            CW           = clog2_min1(DIM);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(DIM - 1);
    localparam logic [CW-1:0] CNT_PASS_END = CW'(DIM - 2);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [DIM*WIDTH-1:0] r_arr;
    logic                 r_in_rdy;
    logic                 r_out_vld;
    logic                 r_out_last;
    logic                 r_busy;

    logic [DIM*WIDTH-1:0] w_pass;
    logic                 w_in_fire;
    logic                 w_out_fire;

    assign w_in_fire  = in_vld & r_in_rdy;
    assign w_out_fire = out_rdy & r_out_vld;

    bsort_chain #(
        .DIM   (DIM),
        .WIDTH (WIDTH)
    ) u_chain (
        .i_arr (r_arr),
        .o_arr (w_pass)
    );

    // NOTE: the element array carries no reset; its contents are only
    // observed after a full load, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_arr[int'(r_cnt)*WIDTH +: WIDTH] <= in_dat;
        end else if (r_state == ST_SORT) begin
            r_arr <= w_pass;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_cnt      <= '0;
            r_in_rdy   <= 1'b1;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt    <= '0;
                            r_state  <= ST_SORT;
                            r_in_rdy <= 1'b0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_SORT: begin
                    // Fixed DIM-1 passes; no early exit on sorted data.
                    if (r_cnt == CNT_PASS_END) begin
                        r_cnt      <= '0;
                        r_state    <= ST_DRAIN;
                        r_out_vld  <= 1'b1;
                        r_out_last <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_out_last) begin
                            r_cnt      <= '0;
                            r_state    <= ST_LOAD;
                            r_out_vld  <= 1'b0;
                            r_out_last <= 1'b0;
                            r_in_rdy   <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_cnt      <= r_cnt + CNT_ONE;
                            r_out_last <= ((r_cnt + CNT_ONE) == CNT_LAST);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_cnt      <= '0;
                    r_in_rdy   <= 1'b1;
                    r_out_vld  <= 1'b0;
                    r_out_last <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_vld  = r_out_vld;
    assign out_last = r_out_last;
    assign busy     = r_busy;
    assign out_dat  = r_arr[int'(r_cnt)*WIDTH +: WIDTH];
    assign out_arr  = r_arr;

endmodule

// File: tb/tb_bsort_stream.sv
// Bench for bsort_stream: table-driven arrays with a scoreboard queue for the
// DIM=8 instance, plus hand-written stall, reset and DIM=2 sequences.
module tb_bsort_stream;

    localparam int DIM   = 8;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0][7:0] din;
        logic [7:0][7:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0]      dat;
        logic            last;
        logic [7:0][7:0] arr;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_dat;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_dat;
    logic             out_vld;
    logic             out_rdy;
    logic             out_last;
    logic [DIM*WIDTH-1:0] out_arr;
    logic             busy;

    logic [7:0]  d2_in_dat;
    logic        d2_in_vld;
    logic        d2_in_rdy;
    logic [7:0]  d2_out_dat;
    logic        d2_out_vld;
    logic        d2_out_rdy;
    logic        d2_out_last;
    logic [15:0] d2_out_arr;
    logic        d2_busy;

    int   n_tests;
    int   n_fail;
    exp_t q[$];
    exp_t m_e;
    vec_t vecs[4];

    bsort_stream #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (in_dat),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .out_arr  (out_arr),
        .busy     (busy)
    );

    bsort_stream #(.DIM(2), .WIDTH(8)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (d2_in_dat),
        .in_vld   (d2_in_vld),
        .in_rdy   (d2_in_rdy),
        .out_dat  (d2_out_dat),
        .out_vld  (d2_out_vld),
        .out_rdy  (d2_out_rdy),
        .out_last (d2_out_last),
        .out_arr  (d2_out_arr),
        .busy     (d2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
        logic [7:0][7:0] p;
        p[0] = 8'(a0); p[1] = 8'(a1); p[2] = 8'(a2); p[3] = 8'(a3);
        p[4] = 8'(a4); p[5] = 8'(a5); p[6] = 8'(a6); p[7] = 8'(a7);
        return p;
    endfunction

    // Scoreboard consumer: every output handshake pops one expected element.
    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            check("in_rdy_in_drain", in_rdy, 0);
            if (out_rdy) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", out_dat);
                end else begin
                    m_e = q.pop_front();
                    check("out_dat", out_dat, m_e.dat);
                    check("out_last", out_last, m_e.last);
                    check("out_arr", out_arr, m_e.arr);
                end
            end
        end
    end

    // Loads one array; optionally waits for the first output and checks latency.
    task automatic load_array(input logic [7:0][7:0] din, input logic [7:0][7:0] exp,
                              input bit gaps, input bit wait_out);
        exp_t e;
        int   n;
        int   lat;
        for (int i = 0; i < DIM; i++) begin
            e.dat  = exp[i];
            e.last = (i == DIM - 1);
            e.arr  = exp;
            q.push_back(e);
        end
        for (int i = 0; i < DIM; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_vld = 1'b0;
                    in_dat = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_vld = 1'b1;
            in_dat = din[i];
            n = 0;
            @(negedge clk);
            while (!in_rdy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("in_rdy_wait", in_rdy, 1);
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        in_dat = 8'($urandom);
        if (wait_out) begin
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (out_vld) begin
                    lat = k;
                    break;
                end
                check("in_rdy_in_sort", in_rdy, 0);
                check("busy_in_sort", busy, 1);
            end
            check("latency", lat, DIM);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain_done", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_and_check();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] held_dat;
        logic       held_last;
        int         lat;

        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_vld     = 1'b0;
        in_dat     = '0;
        out_rdy    = 1'b0;
        d2_in_vld  = 1'b0;
        d2_in_dat  = '0;
        d2_out_rdy = 1'b1;

        vecs[0].din = pk8(7, 6, 5, 4, 3, 2, 1, 0);
        vecs[0].exp = pk8(0, 1, 2, 3, 4, 5, 6, 7);
        vecs[1].din = pk8(255, 0, 3, 3, 255, 1, 0, 128);
        vecs[1].exp = pk8(0, 0, 1, 3, 3, 128, 255, 255);
        vecs[2].din = pk8(1, 2, 10, 20, 30, 40, 200, 250);
        vecs[2].exp = pk8(1, 2, 10, 20, 30, 40, 200, 250);
        vecs[3].din = pk8(5, 200, 5, 17, 0, 99, 42, 5);
        vecs[3].exp = pk8(0, 5, 5, 5, 17, 42, 99, 200);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_in_rdy", in_rdy, 1);
        check("init_out_vld", out_vld, 0);
        check("init_out_last", out_last, 0);
        check("init_busy", busy, 0);
        check("init_d2_in_rdy", d2_in_rdy, 1);
        check("init_d2_out_vld", d2_out_vld, 0);
        @(posedge clk); #1;

        // Table-driven arrays, free-flowing output.
        out_rdy = 1'b1;
        for (int v = 0; v < 4; v++) begin
            load_array(vecs[v].din, vecs[v].exp, 1'b0, 1'b1);
            wait_idle();
        end

        // Input gaps, then a 5-cycle stall on the fourth output element.
        load_array(vecs[3].din, vecs[3].exp, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        @(negedge clk);
        held_dat  = out_dat;
        held_last = out_last;
        check("stall_value", held_dat, vecs[3].exp[3]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_out_dat", out_dat, held_dat);
            check("stall_out_last", out_last, held_last);
            check("stall_out_vld", out_vld, 1);
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        wait_idle();

        // Reset during SORT, then a fresh array.
        load_array(vecs[1].din, vecs[1].exp, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        reset_and_check();
        load_array(vecs[0].din, vecs[0].exp, 1'b0, 1'b1);
        wait_idle();

        // Reset while the fourth element is being offered.
        load_array(vecs[3].din, vecs[3].exp, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset_and_check();
        load_array(vecs[1].din, vecs[1].exp, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back: second array is offered while the first drains.
        load_array(vecs[1].din, vecs[1].exp, 1'b0, 1'b1);
        load_array(vecs[0].din, vecs[0].exp, 1'b0, 1'b1);
        wait_idle();

        // Minimum size instance: DIM=2.
        d2_in_vld = 1'b1;
        d2_in_dat = 8'd9;
        @(posedge clk); #1;
        d2_in_dat = 8'd4;
        @(posedge clk); #1;
        d2_in_vld = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d2_out_vld) begin
                lat = k;
                break;
            end
            check("d2_in_rdy_in_sort", d2_in_rdy, 0);
        end
        check("d2_latency", lat, 2);
        check("d2_out0", d2_out_dat, 4);
        check("d2_last0", d2_out_last, 0);
        check("d2_out_arr", d2_out_arr, 16'h0904);
        @(negedge clk);
        check("d2_out1", d2_out_dat, 9);
        check("d2_last1", d2_out_last, 1);
        @(negedge clk);
        check("d2_done_out_vld", d2_out_vld, 0);
        check("d2_done_in_rdy", d2_in_rdy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
